cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Pipelined multi-nibble adder built from 4-bit carry-lookahead slices.
- Pipeline stage k adds nibble k of the operands with the same g/p lookahead equations as the 4-bit CLA. The carry is registered between stages.
- Provides a valid/ready streaming interface, so it can sit between an operand source and a result consumer in the arithmetic datapath.
- Throughput: one addition per cycle. Latency: NIBBLES cycles.

Parameters:
- NIBBLES, 4, number of 4-bit slices and pipeline stages (>=2). Data width W = 4*NIBBLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b/cin valid
- in_ready  output  1  block accepts operands this cycle
- a  input  W  operand A (unsigned or two's complement)
- b  input  W  operand B
- cin  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  registered sum
- cout  output  1  registered carry out of MSB
- overflow  output  1  registered signed overflow

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - all stage valid bits, out_valid, sum, cout and overflow go to 0;
  - all carry and data pipeline registers go to 0;
  - in_ready=1 in the cycle after reset.
- Global advance: adv = !out_valid || out_ready. Set in_ready = adv, combinational, with no dependence on in_valid.
- Accept: a transfer happens on an edge where in_valid && in_ready.
- Stage 0 (combinational on inputs):
  - computes sum nibble 0 and carry c4 from a[3:0], b[3:0], cin using lookahead g=a&b, p=a^b, c1..c4 expressions;
  - the register bank for stage 1 loads sum[3:0], c4, a[W-1:4], b[W-1:4] and valid=in_valid on edge with adv=1.
- Stage k (1..NIBBLES-1):
  - adds nibble k of its registered operands with its registered carry-in;
  - appends the result nibble to the accumulated lower sum bits;
  - passes remaining upper operand nibbles forward.
- Output stage:
  - the last stage's register bank is the output (sum, cout, overflow, out_valid);
  - overflow = c_in(bit W-1) XOR c_out(bit W-1), computed in the last slice.
- Latency:
  - operands accepted at edge E0 give out_valid=1 immediately after edge E0+NIBBLES-1;
  - for NIBBLES=4 this is after 3 more edges.
- Stall:
  - when adv=0, every pipeline register including data holds;
  - outputs stay stable while out_valid=1 && out_ready=0 (standard valid/ready rule: no change until accepted).
- Bubbles:
  - adv=1 with in_valid=0 shifts a valid=0 slot in;
  - bubbles are not collapsed.
  - Registers of an invalid slot hold their previous contents. Data registers load only when the preceding slot is valid and adv=1, so sum, cout and overflow keep the last result while out_valid=0.
- Ordering:
  - results leave in acceptance order;
  - no loss or duplication under any in_valid/out_ready pattern.
- Simultaneous accept and retire: fully supported in the same cycle at full rate.
- Reset mid-operation: all in-flight operations are discarded; no result from before reset ever appears after it.
- Arithmetic:
  - unsigned modulo 2^W;
  - {cout,sum} = a+b+cin exactly;
  - overflow is meaningful for signed interpretation only.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, sum=0x0000, cout=0, overflow=0; in_ready=1 after release.
- Cross-nibble carry: a=0x00FF, b=0x0001, cin=0, out_ready=1 -> out_valid 3 edges after accept with sum=0x0100, cout=0, overflow=0.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
- Streaming with back-pressure:
  - stimulus: 6 back-to-back operations (a=i*0x1111, b=0x0F0F, i=0..5), with out_ready low for 2 cycles while result 1 is presented;
  - required: in_ready=0 during the stall, sum held stable, all 6 results exact and in order, one per cycle otherwise.
- Bubbles: in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0 delayed by 3 edges; sum holds the previous result during the 0 slots.
- Reset mid-flight: rst=1 for one cycle with 3 ops in flight -> out_valid=0 the next cycle and no stale result ever appears. The next op, 0x1234+0x4321, gives sum=0x5555.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined multi-nibble adder built from 4-bit carry-lookahead
// slices. Nibble 0 is resolved combinationally on the inputs and captured in
// bank 1; every later stage k resolves nibble k from its registered operands
// and registered carry, so a result emerges from bank NIBBLES after NIBBLES
// edges. A single advance signal moves or freezes the whole pipeline, which
// keeps ordering trivially intact and gives full-rate accept/retire.
module cla_pipe_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  // 4-bit carry-lookahead slice. Result layout: {c4, s[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, p ^ {c3, c2, c1, ci}};
  endfunction

  // Signed overflow of a slice holding the MSB: carry into bit 3 XOR carry out.
  // The carry into bit 3 is recovered as s3 ^ x3 ^ y3, so the slice function
  // does not need a separate output for it.
  function automatic logic slice_ovf(input logic [3:0] x,
                                     input logic [3:0] y,
                                     input logic [4:0] res);
    return res[4] ^ (res[3] ^ x[3] ^ y[3]);
  endfunction

  // Pipeline banks 1..NIBBLES; bank NIBBLES drives the outputs directly.
  logic         stg_valid [1:NIBBLES];
  logic [W-1:0] stg_sum   [1:NIBBLES];
  logic         stg_carry [1:NIBBLES];
  // Operands only need to travel to the stage that consumes their top nibble.
  logic [W-1:0] stg_a     [1:NIBBLES-1];
  logic [W-1:0] stg_b     [1:NIBBLES-1];
  logic         ovf_reg;

  logic         adv;
  logic [4:0]   s0_res;
  logic [4:0]   res       [1:NIBBLES-1];
  logic [W-1:0] nxt_sum   [1:NIBBLES-1];
  logic         last_ovf;

  // The pipeline moves whenever the output slot is empty or being consumed.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign out_valid = stg_valid[NIBBLES];
  assign sum       = stg_sum[NIBBLES];
  assign cout      = stg_carry[NIBBLES];
  assign overflow  = ovf_reg;

  // Stage 0: lowest nibble straight from the input operands.
  always_comb begin
    s0_res = cla4(a[3:0], b[3:0], cin);
  end

  // Stages 1..NIBBLES-1: resolve nibble k and splice it into the partial sum.
  always_comb begin
    for (int k = 1; k < NIBBLES; k++) begin
      res[k]                 = cla4(stg_a[k][4*k +: 4], stg_b[k][4*k +: 4], stg_carry[k]);
      nxt_sum[k]             = stg_sum[k];
      nxt_sum[k][4*k +: 4]   = res[k][3:0];
    end
    last_ovf = slice_ovf(stg_a[NIBBLES-1][W-1 -: 4], stg_b[NIBBLES-1][W-1 -: 4],
                         res[NIBBLES-1]);
  end

  // Pipeline registers: valid bits shift on every advance, data of a slot only
  // loads when the slot feeding it is valid, so bubbles leave old data intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= NIBBLES; k++) begin
        stg_valid[k] <= 1'b0;
        stg_sum[k]   <= {W{1'b0}};
        stg_carry[k] <= 1'b0;
      end
      for (int k = 1; k < NIBBLES; k++) begin
        stg_a[k] <= {W{1'b0}};
        stg_b[k] <= {W{1'b0}};
      end
      ovf_reg <= 1'b0;
    end else if (adv) begin
      stg_valid[1] <= in_valid;
      if (in_valid) begin
        stg_sum[1]   <= {{(W-4){1'b0}}, s0_res[3:0]};
        stg_carry[1] <= s0_res[4];
        stg_a[1]     <= a;
        stg_b[1]     <= b;
      end
      for (int k = 1; k < NIBBLES; k++) begin
        stg_valid[k+1] <= stg_valid[k];
        if (stg_valid[k]) begin
          stg_sum[k+1]   <= nxt_sum[k];
          stg_carry[k+1] <= res[k][4];
        end
      end
      for (int k = 1; k < NIBBLES - 1; k++) begin
        if (stg_valid[k]) begin
          stg_a[k+1] <= stg_a[k];
          stg_b[k+1] <= stg_b[k];
        end
      end
      if (stg_valid[NIBBLES-1]) begin
        ovf_reg <= last_ovf;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: randomized and directed checks of cla_pipe_adder against
// a plain-arithmetic reference ({cout,sum} = a+b+cin, signed-overflow rule).
module tb_cla_pipe_adder;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  cla_pipe_adder #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Entries are {overflow, cout, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];
  int           acc_cyc_q[$];
  int           ret_cyc_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {ovf, full};
  endfunction

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); ret_cyc_q.delete();
  endtask

  // One clock cycle: apply inputs, observe handshakes just before the edge,
  // record retired results and model expectations, then step past the edge.
  task automatic drive(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic ordy,
                       output logic acc, output logic rdy_s, output logic vld_s,
                       output logic [W-1:0] sum_s);
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    rdy_s = in_ready; vld_s = out_valid; sum_s = sum;
    acc   = (in_valid && in_ready) === 1'b1;
    if ((out_valid && out_ready) === 1'b1) begin
      got_q.push_back({overflow, cout, sum});
      ret_cyc_q.push_back(cyc);
    end
    if (acc) begin
      exp_q.push_back(model(ia, ib, ic));
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc, r, v;
    logic [W-1:0] s;
    repeat (n) drive(1'b0, '0, '0, 1'b0, ordy, acc, r, v, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
    clear_q();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_cross_carry();
    logic acc, r, v;
    logic [W-1:0] s;
    clear_q();
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, acc, r, v, s);
    idle(7, 1'b1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL carry_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() >= 1 && ret_cyc_q.size() >= 1 && acc_cyc_q.size() >= 1) begin
      n_checks++; if (got_q[0] !== {1'b0, 1'b0, 16'h0100}) begin n_fail++; $display("FAIL carry_result: got %h expected %h", got_q[0], {1'b0, 1'b0, 16'h0100}); end
      // Sampling happens one cycle after the edge, so 3 edges show as NIB cycles.
      n_checks++; if (ret_cyc_q[0] - acc_cyc_q[0] !== NIB) begin n_fail++; $display("FAIL carry_latency: got %0d expected %0d", ret_cyc_q[0] - acc_cyc_q[0], NIB); end
    end
  endtask

  task automatic test_full_ripple();
    logic acc, r, v;
    logic [W-1:0] s;
    clear_q();
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, acc, r, v, s);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, acc, r, v, s);
    idle(7, 1'b1);
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL ripple_count: got %0d expected 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0] !== {1'b0, 1'b1, 16'h0000}) begin n_fail++; $display("FAIL ripple_ffff: got %h expected %h", got_q[0], {1'b0, 1'b1, 16'h0000}); end
      n_checks++; if (got_q[1] !== {1'b1, 1'b0, 16'h8000}) begin n_fail++; $display("FAIL ripple_ovf: got %h expected %h", got_q[1], {1'b1, 1'b0, 16'h8000}); end
      n_checks++; if (ret_cyc_q[1] - ret_cyc_q[0] !== 1) begin n_fail++; $display("FAIL ripple_rate: got %0d expected 1", ret_cyc_q[1] - ret_cyc_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, r, v;
    logic [W-1:0] s;
    logic [W-1:0] want;
    int i;
    clear_q();
    i = 0;
    for (int t = 0; t < 12; t++) begin
      drive(i < 6, 16'(i) * 16'h1111, 16'h0F0F, 1'b0, !(t == 5 || t == 6), acc, r, v, s);
      if (acc) i++;
      if (t == 5 || t == 6) begin
        n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready t=%0d: got %b expected 0", t, r); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid t=%0d: got %b expected 1", t, v); end
      end
      if (t >= 5 && t <= 7) begin
        n_checks++; if (s !== 16'h2020) begin n_fail++; $display("FAIL stall_sum t=%0d: got %h expected 2020", t, s); end
      end
    end
    idle(7, 1'b1);
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL stream_count: got %0d expected 6", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < 6; j++) begin
      want = 16'(j) * 16'h1111 + 16'h0F0F;
      n_checks++; if (got_q[j] !== {2'b00, want}) begin n_fail++; $display("FAIL stream_result[%0d]: got %h expected %h", j, got_q[j], {2'b00, want}); end
      if (j == 1) begin
        n_checks++; if (ret_cyc_q[1] - ret_cyc_q[0] !== 3) begin n_fail++; $display("FAIL stream_stall_gap: got %0d expected 3", ret_cyc_q[1] - ret_cyc_q[0]); end
      end else if (j > 1) begin
        n_checks++; if (ret_cyc_q[j] - ret_cyc_q[j-1] !== 1) begin n_fail++; $display("FAIL stream_rate[%0d]: got %0d expected 1", j, ret_cyc_q[j] - ret_cyc_q[j-1]); end
      end
    end
  endtask

  task automatic test_bubbles();
    logic acc, r;
    logic         vh[8];
    logic [W-1:0] sh[8];
    logic [W-1:0] oa[2];
    logic [W-1:0] ob[2];
    logic [W+1:0] e0, e1;
    clear_q();
    for (int k = 0; k < 2; k++) begin oa[k] = W'($urandom); ob[k] = W'($urandom); end
    e0 = model(oa[0], ob[0], 1'b0);
    e1 = model(oa[1], ob[1], 1'b1);
    for (int t = 0; t < 8; t++) begin
      drive((t < 4) && (t % 2 == 0), oa[t/2 % 2], ob[t/2 % 2], t == 2, 1'b1, acc, r, vh[t], sh[t]);
    end
    for (int t = 0; t < 4; t++) begin
      n_checks++; if (vh[t+4] !== (t % 2 == 0)) begin n_fail++; $display("FAIL bubble_valid t=%0d: got %b expected %b", t + 4, vh[t+4], t % 2 == 0); end
    end
    n_checks++; if (sh[4] !== e0[W-1:0]) begin n_fail++; $display("FAIL bubble_sum0: got %h expected %h", sh[4], e0[W-1:0]); end
    n_checks++; if (sh[5] !== e0[W-1:0]) begin n_fail++; $display("FAIL bubble_hold0: got %h expected %h", sh[5], e0[W-1:0]); end
    n_checks++; if (sh[7] !== e1[W-1:0]) begin n_fail++; $display("FAIL bubble_hold1: got %h expected %h", sh[7], e1[W-1:0]); end
  endtask

  task automatic test_reset_midflight();
    logic acc, r, v;
    logic [W-1:0] s;
    clear_q();
    for (int k = 0; k < 3; k++) drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, acc, r, v, s);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    clear_q();
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, acc, r, v, s);
    n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", v); end
    idle(8, 1'b1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL midreset_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0] !== {2'b00, 16'h5555}) begin n_fail++; $display("FAIL midreset_result: got %h expected %h", got_q[0], {2'b00, 16'h5555}); end
    end
  endtask

  task automatic test_random();
    logic acc, r, v;
    logic [W-1:0] s;
    clear_q();
    for (int t = 0; t < 300; t++) begin
      drive($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, acc, r, v, s);
    end
    idle(8, 1'b1);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      n_checks++; if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL random_result[%0d]: got %h expected %h", j, got_q[j], exp_q[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_cross_carry();
    test_full_ripple();
    test_back_to_back();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
